// File: rtl/alt_vipcti131_common_unpack_ctrl_pkg.sv
// Shared definitions for the frame reader/writer line controllers:
// FSM state encoding and burst sizing helpers.
package alt_vipcti131_common_unpack_ctrl_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CALC   = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_CLEAR  = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   function automatic int unsigned log2ceil(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

   // Number of mem_width-bit words needed to hold line_bits bits (rounded up).
   function automatic logic [63:0] words_per_line(input logic [63:0] line_bits,
                                                  input int unsigned mem_width);
      return (line_bits + 64'(mem_width) - 64'd1) >> log2ceil(mem_width);
   endfunction

endpackage

// File: rtl/alt_vipcti131_common_unpack_ctrl.sv
// Line sequencer for the frame reader unpack path: one burst command per line,
// pixel counting, and an unpacker clear pulse between lines.
module alt_vipcti131_common_unpack_ctrl
   import alt_vipcti131_common_unpack_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WIDTH      = 128,
   parameter int unsigned BITS_PER_PIXEL = 24,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DIM_WIDTH      = 16,
   parameter int unsigned WORDS_WIDTH    = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   go,
   input  logic                   stop,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [ADDR_WIDTH-1:0]  line_stride,
   input  logic [DIM_WIDTH-1:0]   frame_width,
   input  logic [DIM_WIDTH-1:0]   frame_height,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [ADDR_WIDTH-1:0]  cmd_addr,
   output logic [WORDS_WIDTH-1:0] cmd_words,
   input  logic                   pixel_accept,
   output logic                   unpack_clear,
   output logic                   busy,
   output logic                   done,
   output logic [DIM_WIDTH-1:0]   line_count
);

   localparam int unsigned PROD_W = DIM_WIDTH + log2ceil(BITS_PER_PIXEL) + 1;

   logic [2:0]             state;
   logic [DIM_WIDTH-1:0]   lat_width;
   logic [DIM_WIDTH-1:0]   lat_height;
   logic [DIM_WIDTH-1:0]   pix_count;
   logic [ADDR_WIDTH-1:0]  lat_base;
   logic [ADDR_WIDTH-1:0]  lat_stride;
   logic                   abort;
   logic                   abort_req;
   logic                   last_pixel;
   logic                   last_line;
   logic                   zero_geom;
   logic [PROD_W-1:0]      line_bits;
   logic [WORDS_WIDTH-1:0] line_words;

   always_comb begin
      line_bits  = PROD_W'(lat_width) * PROD_W'(BITS_PER_PIXEL);
      line_words = WORDS_WIDTH'(words_per_line(64'(line_bits), MEM_WIDTH));
      abort_req  = abort | stop;
      last_pixel = (pix_count == lat_width - DIM_WIDTH'(1));
      last_line  = (line_count == lat_height - DIM_WIDTH'(1));
      zero_geom  = (lat_width == '0) || (lat_height == '0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cmd_valid    <= 1'b0;
         cmd_addr     <= '0;
         cmd_words    <= '0;
         unpack_clear <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         line_count   <= '0;
         pix_count    <= '0;
         lat_width    <= '0;
         lat_height   <= '0;
         lat_base     <= '0;
         lat_stride   <= '0;
         abort        <= 1'b0;
      end else begin
         unpack_clear <= 1'b0;
         done         <= 1'b0;
         if (stop && (state inside {ST_CALC, ST_ISSUE, ST_DRAIN, ST_CLEAR}))
            abort <= 1'b1;

         case (state)
            ST_IDLE: begin
               abort <= 1'b0;
               if (go) begin
                  lat_width  <= frame_width;
                  lat_height <= frame_height;
                  lat_base   <= base_addr;
                  lat_stride <= line_stride;
                  busy       <= 1'b1;
                  state      <= ST_CALC;
               end
            end

            // Empty geometry is resolved here so done lands two cycles after go.
            ST_CALC: begin
               cmd_addr   <= lat_base;
               cmd_words  <= line_words;
               line_count <= '0;
               if (abort_req || zero_geom) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_FINISH;
               end else begin
                  cmd_valid <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  pix_count <= '0;
                  if (abort_req) begin
                     unpack_clear <= 1'b1;
                     state        <= ST_CLEAR;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (abort_req) begin
                  unpack_clear <= 1'b1;
                  state        <= ST_CLEAR;
               end else if (pixel_accept) begin
                  if (last_pixel) begin
                     unpack_clear <= 1'b1;
                     state        <= ST_CLEAR;
                  end else begin
                     pix_count <= pix_count + DIM_WIDTH'(1);
                  end
               end
            end

            ST_CLEAR: begin
               if (abort_req || last_line) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_FINISH;
               end else begin
                  line_count <= line_count + DIM_WIDTH'(1);
                  cmd_addr   <= cmd_addr + lat_stride;
                  cmd_valid  <= 1'b1;
                  state      <= ST_ISSUE;
               end
            end

            ST_FINISH: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alt_vipcti131_common_unpack_ctrl.sv
// Scoreboard bench for the unpack line controller: directed frames push
// expected commands/clears/done pulses; a negedge monitor checks them.
module tb_alt_vipcti131_common_unpack_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        go = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] base_addr = '0;
   logic [31:0] line_stride = '0;
   logic [15:0] frame_width = '0;
   logic [15:0] frame_height = '0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_words;
   logic        pixel_accept = 1'b0;
   logic        unpack_clear;
   logic        busy;
   logic        done;
   logic [15:0] line_count;

   alt_vipcti131_common_unpack_ctrl #(
      .MEM_WIDTH(128), .BITS_PER_PIXEL(24), .ADDR_WIDTH(32),
      .DIM_WIDTH(16), .WORDS_WIDTH(16)
   ) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .stop(stop),
      .base_addr(base_addr), .line_stride(line_stride),
      .frame_width(frame_width), .frame_height(frame_height),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_words(cmd_words), .pixel_accept(pixel_accept),
      .unpack_clear(unpack_clear), .busy(busy), .done(done),
      .line_count(line_count)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { logic [31:0] addr; logic [15:0] words; int at; } cmd_t;
   typedef struct { logic [15:0] line; int at; } ev_t;

   cmd_t cmd_q[$];
   ev_t  clr_q[$];
   ev_t  done_q[$];

   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic start_frame(input logic [31:0] b, input logic [31:0] s,
                              input logic [15:0] w, input logic [15:0] h, output int g);
      base_addr = b; line_stride = s; frame_width = w; frame_height = h;
      go = 1'b1;
      g = cyc;
      tick;
      go = 1'b0;
   endtask

   task automatic drain_sb(input string name, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (cmd_q.size() == 0 && clr_q.size() == 0 && done_q.size() == 0) break;
         tick;
      end
      chk({name, "_pending"}, 64'(cmd_q.size() + clr_q.size() + done_q.size()), 64'd0);
      cmd_q.delete();
      clr_q.delete();
      done_q.delete();
      repeat (3) tick;
   endtask

   // Monitor: every presented output event must match the oldest expectation.
   cmd_t mc;
   ev_t  me;
   always @(negedge clock) begin
      if (reset_n) begin
         if (cmd_valid && cmd_ready) begin
            if (cmd_q.size() == 0) begin
               total++;
               $display("FAIL cmd_unexpected: got addr 0x%0h words %0d, required none", cmd_addr, cmd_words);
            end else begin
               mc = cmd_q.pop_front();
               chk("cmd_addr", 64'(cmd_addr), 64'(mc.addr));
               chk("cmd_words", 64'(cmd_words), 64'(mc.words));
               if (mc.at >= 0) chk("cmd_cycle", 64'(cyc), 64'(mc.at));
            end
         end
         if (unpack_clear) begin
            if (clr_q.size() == 0) begin
               total++;
               $display("FAIL clear_unexpected: got clear at line %0d, required none", line_count);
            end else begin
               me = clr_q.pop_front();
               chk("clear_line", 64'(line_count), 64'(me.line));
               if (me.at >= 0) chk("clear_cycle", 64'(cyc), 64'(me.at));
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               total++;
               $display("FAIL done_unexpected: got done, required none");
            end else begin
               me = done_q.pop_front();
               chk("done_line", 64'(line_count), 64'(me.line));
               chk("done_busy", 64'(busy), 64'd0);
               if (me.at >= 0) chk("done_cycle", 64'(cyc), 64'(me.at));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g;

      repeat (2) tick;
      chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      chk("rst_cmd_words", 64'(cmd_words), 64'd0);
      chk("rst_clear", 64'(unpack_clear), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_line", 64'(line_count), 64'd0);
      reset_n = 1'b1;
      repeat (2) tick;

      // Two lines of 16 pixels, continuous flow; go and geometry churn mid-frame.
      pixel_accept = 1'b1;
      start_frame(32'h1000, 32'h40, 16'd16, 16'd2, g);
      chk("t1_busy", 64'(busy), 64'd1);
      cmd_q.push_back(cmd_t'{32'h1000, 16'd3, g + 2});
      clr_q.push_back(ev_t'{16'd0, g + 19});
      cmd_q.push_back(cmd_t'{32'h1040, 16'd3, g + 20});
      clr_q.push_back(ev_t'{16'd1, g + 37});
      done_q.push_back(ev_t'{16'd1, g + 38});
      while (cyc < g + 10) tick;
      go = 1'b1; base_addr = 32'hDEAD0000; line_stride = '0;
      frame_width = 16'd3; frame_height = 16'd9;
      tick;
      go = 1'b0;
      drain_sb("t1", 100);

      // Back-pressure on the command port: held stable for 5 cycles.
      cmd_ready = 1'b0;
      start_frame(32'h2000, 32'h100, 16'd6, 16'd1, g);
      cmd_q.push_back(cmd_t'{32'h2000, 16'd2, -1});
      clr_q.push_back(ev_t'{16'd0, -1});
      done_q.push_back(ev_t'{16'd0, -1});
      for (int i = 0; i < 10; i++) begin
         if (cmd_valid) break;
         tick;
      end
      chk("t2_latency", 64'(cyc), 64'(g + 2));
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 64'(cmd_valid), 64'd1);
         chk("t2_hold_addr", 64'(cmd_addr), 64'h2000);
         chk("t2_hold_words", 64'(cmd_words), 64'd2);
         tick;
      end
      cmd_ready = 1'b1;
      drain_sb("t2", 60);

      // Empty geometry: no command, done two cycles after go.
      start_frame(32'h5000, 32'h10, 16'd0, 16'd3, g);
      done_q.push_back(ev_t'{16'd0, g + 2});
      drain_sb("t3w", 20);
      start_frame(32'h5000, 32'h10, 16'd4, 16'd0, g);
      done_q.push_back(ev_t'{16'd0, g + 2});
      drain_sb("t3h", 20);

      // Stop after 5 pixels of line 0 in a 4-line frame.
      pixel_accept = 1'b0;
      start_frame(32'h6000, 32'h80, 16'd8, 16'd4, g);
      cmd_q.push_back(cmd_t'{32'h6000, 16'd2, g + 2});
      clr_q.push_back(ev_t'{16'd0, g + 9});
      done_q.push_back(ev_t'{16'd0, g + 10});
      while (cyc < g + 3) tick;
      pixel_accept = 1'b1;
      repeat (5) tick;
      pixel_accept = 1'b0;
      stop = 1'b1;
      drain_sb("t4", 30);
      stop = 1'b0;
      chk("t4_busy_after", 64'(busy), 64'd0);
      chk("t4_line_after", 64'(line_count), 64'd0);

      // Address wrap at the top of the byte address space.
      pixel_accept = 1'b1;
      start_frame(32'hFFFFFFC0, 32'h40, 16'd4, 16'd2, g);
      cmd_q.push_back(cmd_t'{32'hFFFFFFC0, 16'd1, g + 2});
      clr_q.push_back(ev_t'{16'd0, g + 7});
      cmd_q.push_back(cmd_t'{32'h00000000, 16'd1, g + 8});
      clr_q.push_back(ev_t'{16'd1, g + 13});
      done_q.push_back(ev_t'{16'd1, g + 14});
      drain_sb("t5", 60);

      // Asynchronous reset while draining line 1, then a clean restart.
      start_frame(32'h7000, 32'h20, 16'd4, 16'd3, g);
      cmd_q.push_back(cmd_t'{32'h7000, 16'd1, g + 2});
      clr_q.push_back(ev_t'{16'd0, g + 7});
      cmd_q.push_back(cmd_t'{32'h7020, 16'd1, g + 8});
      while (cyc < g + 11) tick;
      chk("t6_line_pre", 64'(line_count), 64'd1);
      chk("t6_sb_pre", 64'(cmd_q.size() + clr_q.size() + done_q.size()), 64'd0);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("t6_cmd_addr", 64'(cmd_addr), 64'd0);
      chk("t6_cmd_words", 64'(cmd_words), 64'd0);
      chk("t6_clear", 64'(unpack_clear), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      chk("t6_line", 64'(line_count), 64'd0);
      tick;
      reset_n = 1'b1;
      tick;
      start_frame(32'h8000, 32'h10, 16'd4, 16'd1, g);
      cmd_q.push_back(cmd_t'{32'h8000, 16'd1, g + 2});
      clr_q.push_back(ev_t'{16'd0, g + 7});
      done_q.push_back(ev_t'{16'd0, g + 8});
      drain_sb("t6", 40);
      pixel_accept = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
